// File: rtl/ddr3_mcb_cmd_ctl_fsm_if.sv
// ddr3_mcb_cmd_ctl_fsm_if: upstream single-burst request port of the MCB command controller
interface ddr3_mcb_cmd_ctl_fsm_if #(
  parameter int pROW_W = 14,
  parameter int pCOL_W = 10,
  parameter int pBA_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [pBA_W-1:0]  req_ba;
  logic [pROW_W-1:0] req_row;
  logic [pCOL_W-1:0] req_col;
  modport master (output req_valid, req_wr, req_ba, req_row, req_col, input req_ready);
  modport slave  (input req_valid, req_wr, req_ba, req_row, req_col, output req_ready);
endinterface

// File: rtl/ddr3_mcb_cmd_ctl_fsm.sv
// ddr3_mcb_cmd_ctl_fsm: close-page ACT/RD-WR/PRE sequencer with periodic auto-refresh
module ddr3_mcb_cmd_ctl_fsm #(
  parameter int pROW_W = 14,
  parameter int pCOL_W = 10,
  parameter int pBA_W  = 3,
  parameter int pCL    = 6,
  parameter int pTRCD  = 6,
  parameter int pTRAS  = 15,
  parameter int pTRP   = 6,
  parameter int pTWR   = 8,
  parameter int pTRFC  = 64,
  parameter int pTREFI = 3120
) (
  input  logic                 ddr3_mcb_clk,
  input  logic                 ddr3_mcb_rst_n,
  input  logic                 init_done,
  ddr3_mcb_cmd_ctl_fsm_if.slave req,
  output logic                 c_rd,
  output logic                 c_wr,
  output logic                 ddr3_cs_n,
  output logic                 ddr3_ras_n,
  output logic                 ddr3_cas_n,
  output logic                 ddr3_we_n,
  output logic [pBA_W-1:0]     ddr3_ba,
  output logic [pROW_W-1:0]    ddr3_addr,
  output logic                 mcb_idle
);
  typedef enum logic [3:0] {S_IDLE, S_ACT, S_TRCD, S_RW, S_DATA, S_PRE, S_TRP, S_REF, S_TRFC} state_t;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  state_t              state_q, state_d;
  logic [7:0]          tmr_q, tmr_d, tras_q, tras_d;
  logic [12:0]         rcnt_q, rcnt_d;
  logic                ref_pend_q, ref_pend_d, wr_q, wr_d;
  logic [pBA_W-1:0]    ba_q, ba_d, pba_q, pba_d;
  logic [pROW_W-1:0]   row_q, row_d, paddr_q, paddr_d;
  logic [pCOL_W-1:0]   col_q, col_d;
  logic [3:0]          cmd_q, cmd_d;
  logic                c_rd_q, c_rd_d, c_wr_q, c_wr_d;
  logic                wrap, ref_req, ready, accept;
  always_comb begin
    wrap    = init_done && rcnt_q == 13'(pTREFI - 1);
    ref_req = ref_pend_q || wrap;
    ready   = ddr3_mcb_rst_n && init_done && state_q == S_IDLE && !ref_req;
    accept  = ready && req.req_valid;
  end
  assign req.req_ready = ready;
  assign mcb_idle      = ready;
  assign {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = cmd_q;
  assign ddr3_ba   = pba_q;
  assign ddr3_addr = paddr_q;
  assign c_rd      = c_rd_q;
  assign c_wr      = c_wr_q;
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n)
    if (!ddr3_mcb_rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      tras_q     <= '0;
      rcnt_q     <= '0;
      ref_pend_q <= 1'b0;
      wr_q       <= 1'b0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cmd_q      <= CMD_NOP;
      pba_q      <= '0;
      paddr_q    <= '0;
      c_rd_q     <= 1'b0;
      c_wr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tras_q     <= tras_d;
      rcnt_q     <= rcnt_d;
      ref_pend_q <= ref_pend_d;
      wr_q       <= wr_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cmd_q      <= cmd_d;
      pba_q      <= pba_d;
      paddr_q    <= paddr_d;
      c_rd_q     <= c_rd_d;
      c_wr_q     <= c_wr_d;
    end
  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - 8'd1 : '0;
    case (state_q)
      S_IDLE: state_d = !init_done ? S_IDLE : ref_req ? S_REF : req.req_valid ? S_ACT : S_IDLE;
      S_ACT: begin
        state_d = S_TRCD;
        tmr_d   = 8'(pTRCD - 2);
      end
      S_TRCD: state_d = (tmr_q == '0) ? S_RW : S_TRCD;
      S_RW: begin
        state_d = S_DATA;
        tmr_d   = wr_q ? 8'(pTWR + 2) : 8'(pCL + 2);
      end
      S_DATA: state_d = (tmr_q == '0 && tras_q == '0) ? S_PRE : S_DATA;
      S_PRE: begin
        state_d = S_TRP;
        tmr_d   = 8'(pTRP - 2);
      end
      S_TRP: state_d = (tmr_q == '0) ? S_IDLE : S_TRP;
      S_REF: begin
        state_d = S_TRFC;
        tmr_d   = 8'(pTRFC - 2);
      end
      S_TRFC: state_d = (tmr_q == '0) ? S_IDLE : S_TRFC;
      default: state_d = S_IDLE;
    endcase
    tras_d     = (state_d == S_ACT) ? 8'(pTRAS - 1) : (tras_q != '0) ? tras_q - 8'd1 : '0;
    ref_pend_d = (state_d == S_REF) ? 1'b0 : ref_req;
    rcnt_d     = (!init_done || wrap) ? '0 : rcnt_q + 13'd1;
    wr_d       = accept ? req.req_wr  : wr_q;
    ba_d       = accept ? req.req_ba  : ba_q;
    row_d      = accept ? req.req_row : row_q;
    col_d      = accept ? req.req_col : col_q;
  end
  always_comb begin
    cmd_d   = CMD_NOP;
    pba_d   = '0;
    paddr_d = '0;
    c_rd_d  = 1'b0;
    c_wr_d  = 1'b0;
    case (state_d)
      S_ACT: begin
        cmd_d   = CMD_ACT;
        pba_d   = ba_d;
        paddr_d = row_d;
      end
      S_RW: begin
        cmd_d   = wr_q ? CMD_WR : CMD_RD;
        pba_d   = ba_q;
        paddr_d = pROW_W'(col_q);
        c_rd_d  = !wr_q;
        c_wr_d  = wr_q;
      end
      S_PRE: begin
        cmd_d = CMD_PRE;
        pba_d = ba_q;
      end
      S_REF: cmd_d = CMD_REF;
      default: ;
    endcase
  end
endmodule

// File: doc/ddr3_mcb_cmd_ctl_fsm.md
Name: ddr3_mcb_cmd_ctl_fsm

Overview:
- Command-side controller of the DDR3 MCB. Accepts one single-burst access (BL8, 4 controller clocks) at a time from the upstream request port.
- Sequences ACT → RD/WR → PRE (close-page) on the DDR3 command pins and runs periodic auto-refresh.
- Issues the one-cycle c_rd/c_wr strobes that start the data-control FSM, so it is the initiator of that interface.

Parameters:
pROW_W, 14, row address width
pCOL_W, 10, column address width
pBA_W, 3, bank address width
pCL, 6, CAS latency in clocks (must match data FSM)
pTRCD, 6, ACT to RD/WR, clocks
pTRAS, 15, ACT to PRE minimum, clocks
pTRP, 6, PRE to next ACT/REF, clocks
pTWR, 8, write recovery after last write beat, clocks
pTRFC, 64, REF to next command, clocks
pTREFI, 3120, refresh interval, clocks

Ports:
ddr3_mcb_clk  in  1  controller clock
ddr3_mcb_rst_n  in  1  asynchronous active-low reset
init_done  in  1  DDR3 init sequence complete; level
req_valid  in  1  access request valid
req_ready  out  1  block can accept request
req_wr  in  1  1=write, 0=read
req_ba  in  pBA_W  bank
req_row  in  pROW_W  row
req_col  in  pCOL_W  column
c_rd  out  1  one-cycle read start to data FSM
c_wr  out  1  one-cycle write start to data FSM
ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n  out  1 each  command pins
ddr3_ba  out  pBA_W  bank pins
ddr3_addr  out  pROW_W  address pins (A10 included)
mcb_idle  out  1  FSM in IDLE with no pending refresh

Behaviour:
- Clock and reset: one clock, ddr3_mcb_clk. Reset ddr3_mcb_rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - Command = NOP (cs_n=0, ras_n=cas_n=we_n=1); ba=0, addr=0.
  - c_rd=c_wr=0, req_ready=0, mcb_idle=0, refresh counter=0, ref_pend=0.
- Reset asserted mid-operation aborts immediately to the reset values. No PRE is issued.
- Command encodings (cs_n,ras_n,cas_n,we_n):
  - NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010 (A10=0, bank=latched ba), REF 0001 (ba/addr=0).
- Command pins, c_rd and c_wr are registered. Every non-NOP command lasts exactly one cycle; NOP otherwise.
- c_rd is high in the same cycle as RD on the pins; c_wr in the same cycle as WR. For RD/WR: addr[pCOL_W-1:0]=col, upper bits 0, A10=0.
- Handshake:
  - req_ready=1 only in IDLE with init_done=1 and ref_pend=0; combinational from state.
  - Transfer occurs when req_valid&&req_ready at a rising edge. ba/row/col/wr are latched at that edge.
  - req_valid high while req_ready=0 is held off with no side effects.
- States (4-bit): IDLE, ACT, TRCD, RW, DATA, PRE, TRP, REF, TRFC.
- A single down-counter tmr (8 bit) times the waits. A separate tRAS counter starts at ACT.
- Timing, with ACT on pins at cycle n:
  - RD/WR at n+pTRCD.
  - Read: PRE at max(n+pTRAS, RD+pCL+4).
  - Write: PRE at max(n+pTRAS, WR+4+pTWR).
  - req_ready returns at PRE+pTRP.
  - Acceptance at edge T puts ACT on the pins in cycle T+1.
- Refresh:
  - A 13-bit counter is held at 0 while init_done=0. Otherwise it counts every cycle and wraps at pTREFI-1.
  - On wrap it sets ref_pend.
  - In IDLE, ref_pend has priority over req_valid when both occur in the same cycle: REF is issued, ref_pend clears, then the FSM waits pTRFC and returns to IDLE.
  - A wrap during an access only sets ref_pend; the access completes first.
  - A wrap while ref_pend is already 1 is absorbed (no counting of multiple pending refreshes).
- init_done=0: the FSM stays in IDLE and drives NOP; mcb_idle=0.

Test Plan:
- Reset, init_done=1, single read (ba=2,row=0x123,col=0x40) accepted at cycle 0 → ACT ba=2 addr=0x123 at cycle 1; RD+c_rd addr=0x040 at cycle 7; PRE ba=2 at cycle 17; req_ready=1 at cycle 23.
- Single write (ba=5,row=0x3FFF,col=0x3F8) accepted at cycle 0 → ACT at 1; WR+c_wr at 7; PRE at 19; req_ready at 25. c_wr is high for exactly 1 cycle.
- pTREFI=100 override, no requests → REF at cycle 100 after init_done; next REF at 200. req_ready=0 for the 64 cycles following each REF.
- Refresh wrap during a read access → read completes unchanged, then REF issues directly from IDLE before the queued request. The request is accepted pTRFC cycles later.
- Assert ddr3_mcb_rst_n=0 at the TRCD state → outputs go to NOP / c_rd=0 the same cycle (async). After release, a new request is served normally from ACT.
- init_done=0 with req_valid=1 for 50 cycles → req_ready=0, only NOPs, refresh counter stays 0.
